// File: rtl/plab4_net_router_domain_sched.sv
// Time-division scheduler sharing one router input port's request path between two
// security domains, with guard cycles between slots and grant isolation per owner.
module plab4_net_router_domain_sched #(
  parameter int p_slot_cycles = 4,
  parameter int p_dead_cycles = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sched_en,
  input  logic [2:0] reqs_d1,
  input  logic [2:0] reqs_d2,
  input  logic [2:0] grants,
  output logic [2:0] reqs,
  output logic [2:0] grants_d1,
  output logic [2:0] grants_d2,
  output logic       domain,
  output logic       guard,
  output logic       slot_last
);

  localparam int c_max_len   = (p_slot_cycles > p_dead_cycles) ? p_slot_cycles : p_dead_cycles;
  localparam int c_cnt_nbits = $clog2(c_max_len + 1);
  localparam bit c_has_guard = (p_dead_cycles > 0);

  localparam logic [c_cnt_nbits-1:0] c_slot_load = c_cnt_nbits'(p_slot_cycles - 1);
  localparam logic [c_cnt_nbits-1:0] c_dead_load =
    c_cnt_nbits'((p_dead_cycles > 0) ? (p_dead_cycles - 1) : 0);
  localparam logic [c_cnt_nbits-1:0] c_cnt_zero = {c_cnt_nbits{1'b0}};
  localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D1     = 3'd1,
    ST_GUARD1 = 3'd2,
    ST_D2     = 3'd3,
    ST_GUARD2 = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [c_cnt_nbits-1:0] cnt_r;
  logic [c_cnt_nbits-1:0] cnt_next_s;
  logic                   cnt_zero_s;

  assign cnt_zero_s = (cnt_r == c_cnt_zero);

  // State and slot counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= c_cnt_zero;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state rotation; sched_en only matters in IDLE and at the end of the d2 half
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (sched_en) begin
          state_next_s = ST_D1;
          cnt_next_s   = c_slot_load;
        end else begin
          state_next_s = ST_IDLE;
          cnt_next_s   = c_cnt_zero;
        end
      end
      ST_D1: begin
        if (!cnt_zero_s) begin
          cnt_next_s = cnt_r - c_cnt_one;
        end else if (c_has_guard) begin
          state_next_s = ST_GUARD1;
          cnt_next_s   = c_dead_load;
        end else begin
          state_next_s = ST_D2;
          cnt_next_s   = c_slot_load;
        end
      end
      ST_GUARD1: begin
        if (!cnt_zero_s) begin
          cnt_next_s = cnt_r - c_cnt_one;
        end else begin
          state_next_s = ST_D2;
          cnt_next_s   = c_slot_load;
        end
      end
      ST_D2: begin
        if (!cnt_zero_s) begin
          cnt_next_s = cnt_r - c_cnt_one;
        end else if (c_has_guard) begin
          state_next_s = ST_GUARD2;
          cnt_next_s   = c_dead_load;
        end else if (sched_en) begin
          state_next_s = ST_D1;
          cnt_next_s   = c_slot_load;
        end else begin
          state_next_s = ST_IDLE;
          cnt_next_s   = c_cnt_zero;
        end
      end
      ST_GUARD2: begin
        if (!cnt_zero_s) begin
          cnt_next_s = cnt_r - c_cnt_one;
        end else if (sched_en) begin
          state_next_s = ST_D1;
          cnt_next_s   = c_slot_load;
        end else begin
          state_next_s = ST_IDLE;
          cnt_next_s   = c_cnt_zero;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = c_cnt_zero;
      end
    endcase
  end

  // Output decode: only the slot owner sees requests/grants; guard and IDLE drop everything
  always_comb begin
    reqs      = 3'b000;
    grants_d1 = 3'b000;
    grants_d2 = 3'b000;
    domain    = 1'b0;
    guard     = 1'b0;
    slot_last = 1'b0;
    case (state_r)
      ST_IDLE: begin
        domain = 1'b0;
      end
      ST_D1: begin
        reqs      = reqs_d1;
        grants_d1 = grants;
        slot_last = cnt_zero_s;
      end
      ST_GUARD1: begin
        guard = 1'b1;
      end
      ST_D2: begin
        domain    = 1'b1;
        reqs      = reqs_d2;
        grants_d2 = grants;
        slot_last = cnt_zero_s;
      end
      ST_GUARD2: begin
        domain = 1'b1;
        guard  = 1'b1;
      end
      default: begin
        domain = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_plab4_net_router_domain_sched.sv
// Scoreboard bench: a rotation-position model predicts outputs of a default instance
// and of a 1-cycle-slot, no-guard instance driven by the same random stimulus.
module tb_plab4_net_router_domain_sched;

  typedef struct packed {
    logic [2:0] reqs;
    logic [2:0] g1;
    logic [2:0] g2;
    logic       domain;
    logic       guard;
    logic       slot_last;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sched_en = 1'b0;
  logic [2:0] reqs_d1 = 3'b000;
  logic [2:0] reqs_d2 = 3'b000;
  logic [2:0] grants = 3'b000;

  out_t oa, ob;

  plab4_net_router_domain_sched dut_a (
    .clk(clk), .reset(reset), .sched_en(sched_en),
    .reqs_d1(reqs_d1), .reqs_d2(reqs_d2), .grants(grants),
    .reqs(oa.reqs), .grants_d1(oa.g1), .grants_d2(oa.g2),
    .domain(oa.domain), .guard(oa.guard), .slot_last(oa.slot_last)
  );

  plab4_net_router_domain_sched #(.p_slot_cycles(1), .p_dead_cycles(0)) dut_b (
    .clk(clk), .reset(reset), .sched_en(sched_en),
    .reqs_d1(reqs_d1), .reqs_d2(reqs_d2), .grants(grants),
    .reqs(ob.reqs), .grants_d1(ob.g1), .grants_d2(ob.g2),
    .domain(ob.domain), .guard(ob.guard), .slot_last(ob.slot_last)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Model: per instance, whether the rotation runs and the position within one full period
  bit run_m[2];
  int pos_m[2];
  int slot_m[2] = '{4, 1};
  int dead_m[2] = '{1, 0};

  function automatic out_t predict(bit run, int pos, int slot, int dead,
                                   logic [2:0] r1, logic [2:0] r2, logic [2:0] g);
    out_t o;
    o = '0;
    if (run) begin
      if (pos < slot) begin
        o.reqs = r1; o.g1 = g; o.slot_last = (pos == slot - 1);
      end else if (pos < slot + dead) begin
        o.guard = 1'b1;
      end else if (pos < 2 * slot + dead) begin
        o.domain = 1'b1; o.reqs = r2; o.g2 = g; o.slot_last = (pos == 2 * slot + dead - 1);
      end else begin
        o.domain = 1'b1; o.guard = 1'b1;
      end
    end
    return o;
  endfunction

  // Advance both models across one rising edge using the pre-edge inputs
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        run_m[k] = 1'b0;
      end else if (!run_m[k]) begin
        if (sched_en) begin run_m[k] = 1'b1; pos_m[k] = 0; end
      end else begin
        pos_m[k]++;
        if (pos_m[k] == 2 * (slot_m[k] + dead_m[k])) begin
          if (sched_en) pos_m[k] = 0;
          else run_m[k] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic rst, input logic en,
                       input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] g);
    exp_t e;
    reset = rst; sched_en = en; reqs_d1 = r1; reqs_d2 = r2; grants = g;
    if (rst) begin run_m[0] = 1'b0; run_m[1] = 1'b0; end
    e.a = predict(run_m[0], pos_m[0], slot_m[0], dead_m[0], r1, r2, g);
    e.b = predict(run_m[1], pos_m[1], slot_m[1], dead_m[1], r1, r2, g);
    sb_q.push_back(e);
  endtask

  task automatic rand_cycle(input logic en);
    tick();
    drive(1'b0, en, 3'($urandom), 3'($urandom), 3'($urandom));
  endtask

  // Monitor: compares every presented output set against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (oa !== e.a) begin
        errors++;
        $display("FAIL dut_a outputs t=%0t got %b exp %b (reqs,g1,g2,dom,guard,last)", $time, oa, e.a);
      end
      checks++;
      if (ob !== e.b) begin
        errors++;
        $display("FAIL dut_b outputs t=%0t got %b exp %b (reqs,g1,g2,dom,guard,last)", $time, ob, e.b);
      end
      checks++;
      if ((oa.g1 != 3'b000 && oa.g2 != 3'b000) || (ob.g1 != 3'b000 && ob.g2 != 3'b000)) begin
        errors++;
        $display("FAIL grant_isolation t=%0t a=%b/%b b=%b/%b required one side zero",
                 $time, oa.g1, oa.g2, ob.g1, ob.g2);
      end
    end
  end

  initial begin
    int n;
    logic [2:0] g;
    run_m = '{1'b0, 1'b0};
    pos_m = '{0, 0};

    // Reset held with random inputs: everything must be zero
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b1, 1'b1, 3'($urandom), 3'($urandom), 3'b111);
    end
    tick();
    drive(1'b0, 1'b1, 3'b010, 3'b100, 3'b010);

    // Fixed per-domain requests, grants matching one of them
    for (int i = 0; i < 25; i++) begin
      tick();
      g = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b100;
      drive(1'b0, 1'b1, 3'b010, 3'b100, g);
    end

    // Grants stuck high
    for (int i = 0; i < 20; i++) begin
      tick();
      drive(1'b0, 1'b1, 3'($urandom), 3'($urandom), 3'b111);
    end

    for (int i = 0; i < 20; i++) rand_cycle(1'b1);

    // Drop sched_en in the second cycle of a d1 slot, let the rotation drain to IDLE
    n = 0;
    tick();
    while (!(run_m[0] && pos_m[0] == 1) && n < 20) begin
      drive(1'b0, 1'b1, 3'($urandom), 3'($urandom), 3'($urandom));
      tick();
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL wait_d1_cycle2 waited %0d cycles limit 20", n);
    end
    drive(1'b0, 1'b0, 3'($urandom), 3'($urandom), 3'($urandom));
    for (int i = 0; i < 25; i++) rand_cycle(1'b0);
    for (int i = 0; i < 6; i++) rand_cycle(1'b1);

    // Random enable toggling
    for (int i = 0; i < 150; i++) rand_cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

    // Reset asserted in the third cycle of a d2 slot
    for (int i = 0; i < 12; i++) rand_cycle(1'b1);
    n = 0;
    tick();
    while (!(run_m[0] && pos_m[0] == slot_m[0] + dead_m[0] + 2) && n < 40) begin
      drive(1'b0, 1'b1, 3'($urandom), 3'($urandom), 3'($urandom));
      tick();
      n++;
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL wait_d2_cycle3 waited %0d cycles limit 40", n);
    end
    drive(1'b1, 1'b1, 3'b111, 3'b111, 3'b111);
    tick();
    drive(1'b1, 1'b1, 3'b111, 3'b111, 3'b111);
    tick();
    drive(1'b0, 1'b1, 3'($urandom), 3'($urandom), 3'($urandom));
    for (int i = 0; i < 15; i++) rand_cycle(1'b1);

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
